// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-access layer: FSM encoding,
// command-byte field positions and default parameter values.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Command byte layout: {rw, inc, addr[5:0]}
    localparam int CMD_RW  = 7;
    localparam int CMD_INC = 6;

    localparam logic [7:0] DEFAULT_TX_DEF = 8'h5A;
    localparam logic [5:0] RO_ADDR_DEF    = 6'h3F;

    // Even parity of a byte, available for integrity extensions of the bank.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/spi_reg_file.sv
// Flop-based register array: one synchronous write port, one asynchronous
// read port and a dedicated tap of entry 0. All entries reset to zero.
module spi_reg_file import spi_reg_pkg::*; #(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o,
    output logic [7:0]        reg0_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem_q [DEPTH];

    // Storage array: cleared on reset, single write per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
    assign reg0_o  = mem_q[0];

endmodule

// File: rtl/spi_reg_bank.sv
// Byte-level register access behind an SPI slave. A frame carries a command
// byte {rw, inc, addr} followed by data bytes; writes update the register
// file, reads preload tx_data for the slave's next byte slot.
module spi_reg_bank import spi_reg_pkg::*; #(
    parameter int                ADDR_W     = 6,
    parameter logic [7:0]        DEFAULT_TX = DEFAULT_TX_DEF,
    parameter logic [ADDR_W-1:0] RO_ADDR    = RO_ADDR_DEF
) (
    input  logic              clk50m,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    input  logic [7:0]        status_in,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        ctrl_out
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic                rw_q, rw_d;
    logic                inc_q, inc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          tx_q, tx_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;

    logic                we_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [7:0]          rf_rdata_s;
    logic [7:0]          rd_data_s;
    logic [7:0]          reg0_s;

    spi_reg_file #(
        .ADDR_W (ADDR_W)
    ) u_file (
        .clk_i   (clk50m),
        .rst_ni  (rst_n),
        .we_i    (we_s),
        .waddr_i (addr_q),
        .wdata_i (rx_data),
        .raddr_i (rd_addr_s),
        .rdata_o (rf_rdata_s),
        .reg0_o  (reg0_s)
    );

    // Read address for the tx preload: the freshly received command address,
    // the post-increment address of a burst read, or the held address.
    always_comb begin
        rd_addr_s = addr_q;
        if (state_q == ST_CMD) begin
            rd_addr_s = rx_data[ADDR_W-1:0];
        end else if ((state_q == ST_DATA) && inc_q) begin
            rd_addr_s = addr_q + ADDR_ONE;
        end else begin
            rd_addr_s = addr_q;
        end
    end

    assign rd_data_s = (rd_addr_s == RO_ADDR) ? status_in : rf_rdata_s;

    // Frame FSM next-state, command latch, write commit and tx preload.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        inc_d       = inc_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        we_s        = 1'b0;

        if (frame_start) begin
            // A new frame always wins: abort whatever was in flight.
            state_d = ST_CMD;
            tx_d    = DEFAULT_TX;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        rw_d    = rx_data[CMD_RW];
                        inc_d   = rx_data[CMD_INC];
                        addr_d  = rx_data[ADDR_W-1:0];
                        state_d = ST_DATA;
                        if (rx_data[CMD_RW]) begin
                            tx_d = DEFAULT_TX;
                        end else begin
                            tx_d = rd_data_s;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        if (rw_q) begin
                            if (addr_q != RO_ADDR) begin
                                we_s        = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                                wr_data_d   = rx_data;
                            end else begin
                                we_s        = 1'b0;
                            end
                            if (inc_q) begin
                                addr_d = addr_q + ADDR_ONE;
                            end else begin
                                addr_d = addr_q;
                            end
                        end else begin
                            // rd_addr_s already points at addr+1 for bursts.
                            if (inc_q) begin
                                addr_d = addr_q + ADDR_ONE;
                            end else begin
                                addr_d = addr_q;
                            end
                            tx_d = rd_data_s;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = DEFAULT_TX;
                end
            endcase

            // End of frame after the coincident byte has been processed.
            if (frame_end) begin
                state_d = ST_IDLE;
                tx_d    = DEFAULT_TX;
            end else begin
                tx_d    = tx_d;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            inc_q       <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            tx_q        <= DEFAULT_TX;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            inc_q       <= inc_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign tx_data   = tx_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign ctrl_out  = reg0_s;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frames from the test plan
// followed by random frames, checked against a frame-level register model.
module tb_spi_reg_bank;

    logic       clk50m = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       frame_end;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic [7:0] status_in;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] ctrl_out;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mreg [64];
    logic [13:0] exp_w [$];
    logic [13:0] got_w [$];
    logic [7:0]  fb [$];

    always #10 clk50m = ~clk50m;

    spi_reg_bank dut (
        .clk50m      (clk50m),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .status_in   (status_in),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ctrl_out    (ctrl_out)
    );

    // Record every committed write seen on the strobe interface.
    always @(negedge clk50m) begin
        if (wr_strobe === 1'b1) got_w.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mrd(input int a);
        return (a == 63) ? status_in : mreg[a];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk50m);
    endtask

    task automatic pulse_byte(input logic [7:0] b, input logic fs, input logic fe);
        @(negedge clk50m);
        rx_valid = 1'b1; rx_data = b; frame_start = fs; frame_end = fe;
        @(negedge clk50m);
        rx_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk50m); frame_start = 1'b1;
        @(negedge clk50m); frame_start = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk50m); frame_end = 1'b1;
        @(negedge clk50m); frame_end = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, " nwrites"}, 16'(got_w.size()), 16'(exp_w.size()));
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) check({tag, " write"}, {2'b00, got_w[i]}, {2'b00, exp_w[i]});
        got_w.delete();
        exp_w.delete();
    endtask

    // Play the bytes in fb as one complete frame and check against the model.
    task automatic run_frame(input string tag);
        int a;
        bit rw, inc;
        logic [7:0] exp_tx;
        logic [7:0] cmd;
        a = 0; rw = 1'b0; inc = 1'b0;
        start_frame();
        idle(1);
        check({tag, " tx cmd slot"}, {8'h00, tx_data}, 16'h005A);
        for (int i = 0; i < fb.size(); i++) begin
            pulse_byte(fb[i], 1'b0, 1'b0);
            if (i == 0) begin
                cmd = fb[0];
                rw  = cmd[7];
                inc = cmd[6];
                a   = int'(cmd & 8'h3F);
                exp_tx = rw ? 8'h5A : mrd(a);
            end else if (rw) begin
                if (a != 63) begin
                    mreg[a] = fb[i];
                    exp_w.push_back({6'(a), fb[i]});
                end
                if (inc) a = (a + 1) % 64;
                exp_tx = 8'h5A;
            end else begin
                if (inc) a = (a + 1) % 64;
                exp_tx = mrd(a);
            end
            check({tag, " tx"}, {8'h00, tx_data}, {8'h00, exp_tx});
            idle(2);
        end
        end_frame();
        idle(1);
        check({tag, " tx idle"}, {8'h00, tx_data}, 16'h005A);
        check_writes(tag);
        check({tag, " ctrl_out"}, {8'h00, ctrl_out}, {8'h00, mreg[0]});
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; status_in = 8'h00;
        for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
        idle(3);
        check("reset tx", {8'h00, tx_data}, 16'h005A);
        check("reset strobe", {15'h0, wr_strobe}, 16'h0000);
        check("reset wr_addr", {10'h0, wr_addr}, 16'h0000);
        check("reset wr_data", {8'h00, wr_data}, 16'h0000);
        check("reset ctrl", {8'h00, ctrl_out}, 16'h0000);
        rst_n = 1'b1;
        idle(2);

        // Bytes outside a frame are ignored.
        pulse_byte(8'hC0, 1'b0, 1'b0);
        pulse_byte(8'h77, 1'b0, 1'b0);
        idle(2);
        check_writes("idle bytes");

        fb = '{8'hB5, 8'h10};             run_frame("single write");
        check("reg35 model", {8'h00, mreg[53]}, 16'h0010);
        fb = '{8'h35, 8'h00};             run_frame("single read");
        fb = '{8'hFE, 8'h11, 8'h22, 8'h33}; run_frame("burst write");
        check("burst ctrl", {8'h00, ctrl_out}, 16'h0033);
        status_in = 8'hC3;
        fb = '{8'h7E, 8'h00, 8'h00};      run_frame("burst read");

        // Command then frame_end: nothing written.
        start_frame();
        pulse_byte(8'h81, 1'b0, 1'b0);
        end_frame();
        idle(2);
        check_writes("abort");
        fb = '{8'h01, 8'h00};             run_frame("reg1 kept");

        // Data byte coincident with frame_end is committed; then IDLE.
        start_frame();
        pulse_byte(8'h81, 1'b0, 1'b0);
        pulse_byte(8'h44, 1'b0, 1'b1);
        mreg[1] = 8'h44;
        exp_w.push_back({6'd1, 8'h44});
        idle(2);
        check("end+rx tx", {8'h00, tx_data}, 16'h005A);
        pulse_byte(8'h99, 1'b0, 1'b0);
        idle(2);
        check_writes("end+rx");

        // frame_start coincident with a byte: byte ignored, next byte is the command.
        pulse_byte(8'h82, 1'b1, 1'b0);
        check("fs+rx tx", {8'h00, tx_data}, 16'h005A);
        pulse_byte(8'h01, 1'b0, 1'b0);
        check("fs+rx read", {8'h00, tx_data}, {8'h00, mreg[1]});
        pulse_byte(8'h55, 1'b0, 1'b0);
        end_frame();
        idle(2);
        check_writes("fs+rx");

        // Reset mid-frame.
        start_frame();
        pulse_byte(8'hB5, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(1);
        for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
        check("mid rst tx", {8'h00, tx_data}, 16'h005A);
        check("mid rst strobe", {15'h0, wr_strobe}, 16'h0000);
        check("mid rst wr_addr", {10'h0, wr_addr}, 16'h0000);
        check("mid rst wr_data", {8'h00, wr_data}, 16'h0000);
        check("mid rst ctrl", {8'h00, ctrl_out}, 16'h0000);
        rst_n = 1'b1;
        idle(1);
        got_w.delete();
        pulse_byte(8'h10, 1'b0, 1'b0);
        idle(2);
        check_writes("post rst byte");
        fb = '{8'h35, 8'h00};             run_frame("post rst read");

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            int len;
            status_in = 8'($urandom);
            len = $urandom_range(1, 6);
            fb.delete();
            for (int k = 0; k < len; k++) fb.push_back(8'($urandom));
            if (f % 4 == 0) fb[0][5:0] = 6'($urandom_range(60, 63));
            run_frame($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
